// File: rtl/struct_record_pkg.sv
// Shared types for the record assembler: record layout, FSM states, frame length.
// Build option STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN adds the B4 XOR checksum byte.
package struct_record_pkg;

    typedef struct packed {
        logic [7:0]  xx;
        logic        yy;
        logic [15:0] zz;
    } rec_t;

`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
    typedef enum logic [2:0] {S_XX, S_FLG, S_ZH, S_ZL, S_CK} state_t;
    localparam int FRAME_LEN = 5;
`else
    typedef enum logic [2:0] {S_XX, S_FLG, S_ZH, S_ZL} state_t;
    localparam int FRAME_LEN = 4;
`endif

    localparam logic [7:0] FLAG_RSVD_MASK = 8'hFE;

endpackage

// File: rtl/struct_record_fifo.sv
// First-word-fall-through FIFO of rec_t; the head entry is always visible on head.
// Unaffected by STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN.
module struct_record_fifo
    import struct_record_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rec_t             push_data,
    input  logic             pop,
    output rec_t             head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is cleared so the head reads as zero while empty after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/struct_record_assembler.sv
// Byte-stream to rec_t framer with drop/error counting and an output FIFO.
// Define STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN for 5-byte frames with an XOR checksum.
module struct_record_assembler
    import struct_record_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_sof,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [24:0]          out_rec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       xx_q;
    logic [7:0]       flg_q;
    logic [7:0]       zh_q;
    logic [CNT_W-1:0] fifo_count;
    logic             accept;
    logic             last;
    logic             frame_ok;
    logic             push;
    logic             pop;
    logic             err_inc;
    rec_t             push_rec;
    rec_t             head_rec;

    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
    logic [7:0] zl_q;
    logic [7:0] ck_acc;

    assign last     = (state == S_CK);
    assign frame_ok = ((flg_q & FLAG_RSVD_MASK) == 8'h00) && (in_data == ck_acc);
    assign push_rec = '{xx: xx_q, yy: flg_q[0], zz: {zh_q, zl_q}};
`else
    assign last     = (state == S_ZL);
    assign frame_ok = ((flg_q & FLAG_RSVD_MASK) == 8'h00);
    assign push_rec = '{xx: xx_q, yy: flg_q[0], zz: {zh_q, in_data}};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_XX;
        else        state <= state_nxt;
    end

    // An sof byte always restarts the frame, whatever state we were in.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (in_sof) begin
                state_nxt = S_FLG;
            end else begin
                case (state)
                    S_XX:    state_nxt = S_XX;
                    S_FLG:   state_nxt = S_ZH;
                    S_ZH:    state_nxt = S_ZL;
`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
                    S_ZL:    state_nxt = S_CK;
`endif
                    default: state_nxt = S_XX;
                endcase
            end
        end
    end

    always_comb begin
        push    = 1'b0;
        err_inc = 1'b0;
        if (accept) begin
            if (in_sof) begin
                err_inc = (state != S_XX);
            end else if (state == S_XX) begin
                err_inc = 1'b1;
            end else if (last) begin
                push    = frame_ok;
                err_inc = !frame_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xx_q   <= '0;
            flg_q  <= '0;
            zh_q   <= '0;
`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
            zl_q   <= '0;
            ck_acc <= '0;
`endif
        end else if (accept) begin
            if (in_sof) begin
                xx_q   <= in_data;
`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
                ck_acc <= in_data;
`endif
            end else begin
                case (state)
                    S_FLG:   flg_q <= in_data;
                    S_ZH:    zh_q  <= in_data;
`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
                    S_ZL:    zl_q  <= in_data;
`endif
                    default: ;
                endcase
`ifdef STRUCT_RECORD_ASSEMBLER_CHECKSUM_EN
                if (state != S_XX && state != S_CK) ck_acc <= ck_acc ^ in_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                        err_cnt <= '0;
        else if (err_inc && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end

    struct_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_rec),
        .pop      (pop),
        .head     (head_rec),
        .valid    (out_valid),
        .count    (fifo_count)
    );

    assign out_rec = head_rec;

endmodule
